// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath mux select values.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Must match the ALU's operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct fields onto the ALU operation select.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Only R-type (op[5]=1) may select sub; addi ignores instruction bit 30
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath: sequences each
// instruction and drives mux selects, write enables and the ALU select.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] AluControl
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write;

    // State register; reset drops straight back to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state: op is stable after FETCH since IR only loads there
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // Write enables are gated by reset so nothing commits while it is held
    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign IRWrite  = ~reset & ir_write;
    assign MemWrite = ~reset & mem_write;
    assign RegWrite = ~reset & reg_write;
    assign AdrSrc   = adr_src;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (AluControl)
    );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RV32I datapath; sits directly upstream of the ALU and drives its 3-bit `AluControl` select plus every datapath mux select and write enable. A Moore FSM steps each instruction through Fetch/Decode/Execute/Writeback. A combinational ALU decoder turns ALUOp/funct fields into the ALU's operation code. Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

## Interface
- No parameters; all widths fixed by RV32I encoding.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: instruction[6:0].
- `funct3` in 3: instruction[14:12].
- `funct7b5` in 1: instruction[30].
- `zero` in 1: ALU zero flag, combinational from the current cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select (0 PC, 1 ALUOut).
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction/OldPC register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 register A.
- `ALUSrcB` out 2: 00 register B, 01 ImmExt, 10 constant 4.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `AluControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTER for R, EXECUTEI for I, BEQ for beq, JAL for jal; any other op→FETCH, treated as a NOP.
  - MEMADR→MEMREAD for lw, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI and JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ→FETCH.
- Per-state outputs (unlisted fields 0, ALUOp 00):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01.
  - MEMADR: ALUSrcA 10, ALUSrcB 01.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, PCUpdate 1.
- `PCWrite = PCUpdate | (Branch & zero)`. This is the only output path that depends on `zero`.
- ALU decoder:
  - ALUOp 00→000; ALUOp 01→001.
  - ALUOp 10 by funct3: 000→001 if (`op[5]` & `funct7b5`), else 000; 010→101; 110→011; 111→010; any other funct3→000.
- `ImmSrc` is purely combinational from `op`: sw→01, beq→10, jal→11, all else 00.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from state and the instruction fields.
- Instruction latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, unknown opcode 2.
- Reset behaviour:
  - On `reset` assertion, state goes to FETCH immediately, asynchronously.
  - While `reset` is high, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0.
  - All other outputs carry FETCH values while `reset` is high: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, AluControl 000. `ImmSrc` follows `op`.
- After reset deassertion, the first rising edge performs a FETCH: IRWrite=1 and PCWrite=1 are sampled by the datapath.
- Reset mid-instruction abandons the instruction. No write enable is asserted after `reset` rises.
- The `op`/`funct` inputs are stable from DECODE onward because IR is only written in FETCH. The controller does not latch them.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum;
  - opcode constants;
  - AluControl codes (must match the ALU: 000/001/010/011/101);
  - the ALUOp, ALUSrcA/B, ResultSrc and ImmSrc encodings.
- Sub-module `alu_decoder`: inputs ALUOp[1:0], funct3, funct7b5, op5; output AluControl.
- The FSM and the ImmSrc decode stay in `multicycle_controller`.

## Test plan
- Reset, then lw (op 0000011):
  - states FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH, 5 cycles;
  - RegWrite=1 only in MEMWB with ResultSrc 01;
  - AluControl 000 in MEMADR.
- R-type sub (funct3 000, funct7b5 1): EXECUTER shows AluControl 001, ALUSrcB 00. Same with addi (op 0010011, funct7b5 1) gives 000.
- slt/or/and (funct3 010/110/111): AluControl 101/011/010 in EXECUTER. ALUWB follows with RegWrite 1.
- beq:
  - with `zero`=1 in BEQ, PCWrite=1 and AluControl 001;
  - with `zero`=0, PCWrite=0;
  - both cases return to FETCH after 3 cycles.
- sw then jal:
  - sw: MemWrite=1 only in MEMWRITE, ImmSrc 01;
  - jal: JAL state PCWrite=1, ALUSrcA 01, ALUSrcB 10, ImmSrc 11, then ALUWB with RegWrite 1.
- Reset asserted asynchronously in MEMREAD:
  - state is FETCH before the next edge;
  - all four write enables are 0 while reset is high;
  - unknown op 1111111 loops DECODE→FETCH with no write enable asserted in DECODE.
